// File: rtl/pdm_demod.sv
// ============================================================================
// Module   : pdm_demod
// Brief    : 2nd-order CIC decimator recovering PCM samples from a PDM stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pdm_demod #(
    parameter int PDM_WIDTH    = 2,
    parameter int SAMPLE_WIDTH = 5,
    parameter int LOG2_DECIM   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PDM_WIDTH-1:0]    pdm_in,
    input  logic                    pdm_valid,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sample_valid
);

    localparam int W = PDM_WIDTH + 2 * LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    logic [W-1:0]            i1_q, i1_d, i2_q, i2_d;
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic [W-1:0]            x_q, x_d;
    logic                    strobe_q, strobe_d;
    logic [W-1:0]            d1_q, d1_d, d2_q, d2_d;
    logic [W-1:0]            y_q, y_d;
    logic                    y_vld_q, y_vld_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic [W-1:0]            comb_c1, comb_y;

    always_comb begin
        i1_d           = i1_q;
        i2_d           = i2_q;
        cnt_d          = cnt_q;
        x_d            = x_q;
        strobe_d       = 1'b0;
        d1_d           = d1_q;
        d2_d           = d2_q;
        y_d            = y_q;
        y_vld_d        = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        comb_c1        = x_q - d1_q;
        comb_y         = comb_c1 - d2_q;

        // Integrators chain within the cycle: i2 accumulates the updated i1.
        if (pdm_valid) begin
            i1_d  = i1_q + {{(W-PDM_WIDTH){1'b0}}, pdm_in};
            i2_d  = i2_q + i1_d;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                x_d      = i2_d;
                strobe_d = 1'b1;
            end
        end

        if (strobe_q) begin
            d1_d    = x_q;
            d2_d    = comb_c1;
            y_d     = comb_y;
            y_vld_d = 1'b1;
        end

        // Output register gives a fixed two-clock latency from the last input.
        if (y_vld_q) begin
            sample_d       = y_q[W-1 -: SAMPLE_WIDTH];
            sample_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1_q           <= '0;
            i2_q           <= '0;
            cnt_q          <= '0;
            x_q            <= '0;
            strobe_q       <= 1'b0;
            d1_q           <= '0;
            d2_q           <= '0;
            y_q            <= '0;
            y_vld_q        <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            i1_q           <= i1_d;
            i2_q           <= i2_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            strobe_q       <= strobe_d;
            d1_q           <= d1_d;
            d2_q           <= d2_d;
            y_q            <= y_d;
            y_vld_q        <= y_vld_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_demod.sv
// ============================================================================
// Module   : tb_pdm_demod
// Brief    : Scoreboard bench for pdm_demod with a convolution reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pdm_demod;

    localparam int R  = 16;
    localparam int W  = 10;
    localparam int SW = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] pdm_in = 2'd0;
    logic       pdm_valid = 1'b0;
    logic [4:0] sample;
    logic       sample_valid;

    pdm_demod #(.PDM_WIDTH(2), .SAMPLE_WIDTH(5), .LOG2_DECIM(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pdm_in       (pdm_in),
        .pdm_valid    (pdm_valid),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int s;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   nvalid   = 0;
    int   hand_exp = -1;
    int   checks   = 0;
    int   passes   = 0;
    int   mod_acc  = 0;
    int   lb_codes[3] = '{5, 13, 22};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Direct-form CIC2 reference: triangular impulse response over 2R-1 taps.
    function automatic int model_sample();
        int y = 0;
        int n = hist.size();
        for (int k = 0; k < 2*R-1; k++)
            if (n-1-k >= 0) y += ((k < R) ? k+1 : 2*R-1-k) * hist[n-1-k];
        y = y % (1 << W);
        return y >> (W - SW);
    endfunction

    task automatic send_one(input int v, input int gap);
        exp_t e;
        logic [1:0] lv;
        lv = v[1:0];
        repeat (gap) begin
            @(negedge clk);
            pdm_valid = 1'b0;
        end
        @(negedge clk);
        pdm_in    = lv;
        pdm_valid = 1'b1;
        @(posedge clk);
        #1;
        pdm_valid = 1'b0;
        hist.push_back(v);
        nvalid++;
        if (nvalid % R == 0) begin
            e.s = (hand_exp >= 0) ? hand_exp : model_sample();
            e.t = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_group(input int v, input int gap, input int hexp);
        hand_exp = hexp;
        for (int i = 0; i < R; i++) send_one(v, gap);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        hist.delete();
        nvalid = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // First-order error-feedback modulator: 2-bit levels averaging code/8.
    function automatic int mod_step(input int code);
        int s, lvl;
        s   = mod_acc + code;
        lvl = s >> 3;
        if (lvl > 3) lvl = 3;
        mod_acc = s - lvl * 8;
        return lvl;
    endfunction

    always @(negedge clk) begin
        if (reset_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample_value", int'(sample), e.s);
                check("sample_latency", cyc, e.t);
            end
        end
    end

    initial begin
        int s, prev, last;
        repeat (3) @(negedge clk);
        #1;
        check("reset_sample", int'(sample), 0);
        check("reset_valid", int'(sample_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Constant 1: transient then steady gain.
        send_group(1, 0, 4);
        for (int g = 0; g < 3; g++) send_group(1, 0, 8);

        do_reset();
        send_group(3, 0, 12);
        send_group(3, 0, 24);
        send_group(3, 0, 24);

        do_reset();
        for (int g = 0; g < 3; g++) send_group(0, 0, 0);

        // Gapped strobe: valid every third cycle.
        do_reset();
        send_group(1, 2, 4);
        send_group(1, 2, 8);
        send_group(1, 2, 8);

        // Long run with integrator wrap, then a step down.
        do_reset();
        for (int g = 0; g < 63; g++) send_group(3, 0, -1);
        send_group(3, 0, 24);
        send_group(1, 0, -1);
        send_group(1, 0, -1);
        send_group(1, 0, 8);
        send_group(1, 0, 8);

        // Asynchronous reset partway through a group.
        do_reset();
        send_group(1, 0, 4);
        send_group(1, 0, 8);
        drain();
        hand_exp = -1;
        for (int i = 0; i < 7; i++) send_one(1, 0);
        @(negedge clk);
        check("pre_reset_sample", int'(sample), 8);
        reset_n = 1'b0;
        #1;
        check("async_reset_sample", int'(sample), 0);
        check("async_reset_valid", int'(sample_valid), 0);
        exp_q.delete();
        hist.delete();
        nvalid = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_group(1, 0, 4);

        // Loopback from the modulator model.
        do_reset();
        prev = -1;
        for (int c = 0; c < 3; c++) begin
            last = 0;
            for (int g = 0; g < 5; g++) begin
                hand_exp = -1;
                for (int i = 0; i < R; i++) send_one(mod_step(lb_codes[c]), 0);
                drain();
                if (g == 4) check("loopback_constant", int'(sample), last);
                last = int'(sample);
            end
            s = int'(sample);
            check("loopback_within_1lsb",
                  ((s - lb_codes[c] <= 1) && (lb_codes[c] - s <= 1)) ? 1 : 0, 1);
            if (c > 0) check("loopback_monotonic", (s > prev) ? 1 : 0, 1);
            prev = s;
        end

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("outputs_outstanding", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
